// File: rtl/md5_search_ctrl.sv
// md5_search_ctrl: issues an inclusive candidate range into the MD5 pipeline
// at one value per clock. Tracks in-flight candidates with a valid shift
// register and captures the first candidate whose comparator result hits.
module md5_search_ctrl #(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] range_lo,
  input  logic [WIDTH-1:0] range_hi,
  output logic [WIDTH-1:0] counter_out,
  output logic             valid_out,
  input  logic             match_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] found_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_issue_cnt;
  logic [WIDTH-1:0]      r_check_cnt;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_found_value;
  logic                  r_found;
  logic [PIPE_DEPTH-1:0] r_inflight;
  logic                  w_tail;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_issue_next;
  logic                  w_drain_empty;

  // Tail of the in-flight register marks the candidate whose result is on match_in.
  assign w_tail = r_inflight[PIPE_DEPTH-1];
  // In DRAIN nothing new enters, so the register empties when all but the tail are clear.
  assign w_drain_empty = (r_inflight[PIPE_DEPTH-2:0] == '0);

  assign counter_out = r_issue_cnt;
  assign found       = r_found;
  assign found_value = r_found_value;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and status outputs; abort overrides every other decision.
  always_comb begin
    w_state_next = r_state;
    valid_out    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_hit        = 1'b0;
    w_issue_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (range_lo > range_hi) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        if (w_tail && match_in) begin
          w_hit        = 1'b1;
          w_state_next = S_DONE;
        end else if (r_issue_cnt == r_hi) begin
          // Compare before increment so the top of the counter range never wraps.
          w_state_next = S_DRAIN;
        end else begin
          w_issue_next = 1'b1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_tail && match_in) begin
          w_hit        = 1'b1;
          w_state_next = S_DONE;
        end else if (w_drain_empty) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (range_lo > range_hi) ? S_DONE : S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
      w_hit        = 1'b0;
      w_issue_next = 1'b0;
    end
  end

  // In-flight valid shift register; emptied on abort and on a new sweep so stale results never qualify.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inflight <= '0;
    end else if (abort || w_accept) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= {r_inflight[PIPE_DEPTH-2:0], valid_out};
    end
  end

  // Issue and check counters; check_cnt follows the candidate leaving the pipeline.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_issue_cnt <= '0;
      r_check_cnt <= '0;
      r_hi        <= '0;
    end else if (w_accept) begin
      r_hi        <= range_hi;
      r_check_cnt <= range_lo;
      // An empty range never issues, so counter_out keeps its previous value.
      if (w_state_next == S_RUN) begin
        r_issue_cnt <= range_lo;
      end
    end else begin
      if (w_issue_next) begin
        r_issue_cnt <= r_issue_cnt + WIDTH'(1);
      end
      if (w_tail) begin
        r_check_cnt <= r_check_cnt + WIDTH'(1);
      end
    end
  end

  // Match capture: cleared by a new sweep, set by the first hit, held through abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_found       <= 1'b0;
      r_found_value <= '0;
    end else if (w_accept) begin
      r_found       <= 1'b0;
      r_found_value <= '0;
    end else if (w_hit) begin
      r_found       <= 1'b1;
      r_found_value <= r_check_cnt;
    end
  end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// tb_md5_search_ctrl: drives sweeps through md5_search_ctrl with a fixed-latency
// comparator stand-in that hits when a chosen target value comes back out.
module tb_md5_search_ctrl;
  localparam int W = 32;
  localparam int D = 16;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         match_in = 1'b0;
  logic [W-1:0] range_lo = '0;
  logic [W-1:0] range_hi = '0;
  logic [W-1:0] counter_out;
  logic         valid_out;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] found_value;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Issue history used by the comparator stand-in.
  logic         hv [256];
  logic [W-1:0] hd [256];
  bit           match_force = 1'b0;
  bit           target_en   = 1'b0;
  logic [W-1:0] target_r    = '0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] tgt;
    bit          has_t;
    bit          exp_found;
    logic [31:0] exp_fv;
    int          exp_done;
  } vec_t;
  vec_t tbl [8];

  md5_search_ctrl #(.WIDTH(W), .PIPE_DEPTH(D)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start(start),
    .abort(abort),
    .range_lo(range_lo),
    .range_hi(range_hi),
    .counter_out(counter_out),
    .valid_out(valid_out),
    .match_in(match_in),
    .busy(busy),
    .done(done),
    .found(found),
    .found_value(found_value)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge, log the issued value, drive match_in for this cycle.
  task automatic step();
    int old;
    @(negedge CLK);
    cyc++;
    hv[cyc % 256] = valid_out;
    hd[cyc % 256] = counter_out;
    old = (cyc - D) % 256;
    if (match_force) match_in = 1'b1;
    else if (cyc >= D && target_en && hv[old] === 1'b1 && hd[old] == target_r) match_in = 1'b1;
    else match_in = 1'b0;
  endtask

  // Expected sweep timeline from the range rules: observation j is the cycle after edge t+j.
  function automatic void model(input logic [31:0] lo, input logic [31:0] hi,
                                input logic [31:0] tgt, input bit has_t,
                                output bit empty, output bit hit,
                                output longint done_obs, output longint valid_end);
    longint n, k;
    empty = (lo > hi);
    n = longint'({32'd0, hi}) - longint'({32'd0, lo}) + 1;
    k = longint'({32'd0, tgt}) - longint'({32'd0, lo});
    hit = !empty && has_t && (tgt >= lo) && (tgt <= hi);
    if (empty) begin
      done_obs = 0;
      valid_end = 0;
    end else if (hit) begin
      done_obs = k + D + 1;
      valid_end = (n < k + D + 1) ? n : k + D + 1;
    end else begin
      done_obs = n + D;
      valid_end = n;
    end
  endfunction

  task automatic run_sweep(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tgt,
                           input bit has_t, input int poke,
                           output int got_done, output bit got_found, output logic [31:0] got_fv);
    bit empty, hit, ev, eb, ef;
    longint done_obs, vend, lo64;
    logic [31:0] eco, efv;
    model(lo, hi, tgt, has_t, empty, hit, done_obs, vend);
    lo64 = longint'({32'd0, lo});
    target_r = tgt;
    target_en = has_t;
    range_lo = lo;
    range_hi = hi;
    start = 1'b1;
    got_done = -1;
    for (int j = 0; j < int'(done_obs) + 3; j++) begin
      step();
      start = 1'b0;
      if (j == poke && j + 1 < done_obs) begin
        start = 1'b1;
        range_lo = 32'h900;
        range_hi = 32'h90F;
      end
      ev  = (j < vend);
      eb  = (j < done_obs);
      ef  = hit && (j >= done_obs);
      efv = ef ? tgt : 32'h0;
      eco = ev ? 32'(lo64 + j) : 32'(lo64 + vend - 1);
      chk("flags{valid,busy,done,found}", 64'({valid_out, busy, done, found}), 64'({ev, eb, !eb, ef}));
      if (ev || vend > 0) chk("counter_out", 64'(counter_out), 64'(eco));
      chk("found_value", 64'(found_value), 64'(efv));
      if (done === 1'b1 && got_done < 0) got_done = j;
    end
    got_found = found;
    got_fv = found_value;
    target_en = 1'b0;
    repeat (D + 2) step();
  endtask

  initial begin
    int gd;
    bit gf, e, h;
    logic [31:0] gfv, lo, hi, tg;
    longint dob, ve, hi64;
    int len, poke;
    bit ht;

    for (int i = 0; i < 256; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end

    tbl[0] = '{32'h100, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0, 4 + D};
    tbl[1] = '{32'h0, 32'hFF, 32'h42, 1'b1, 1'b1, 32'h42, 32'h42 + D + 1};
    tbl[2] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1 + D + 1};
    tbl[3] = '{32'h5, 32'h3, 32'h0, 1'b0, 1'b0, 32'h0, 0};
    tbl[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'h0, 2 + D};
    tbl[5] = '{32'h7, 32'h7, 32'h7, 1'b1, 1'b1, 32'h7, D + 1};
    tbl[6] = '{32'h200, 32'h20F, 32'h300, 1'b1, 1'b0, 32'h0, 16 + D};
    tbl[7] = '{32'h0, 32'h2F, 32'h2F, 1'b1, 1'b1, 32'h2F, 32'h2F + D + 1};

    // Reset state.
    repeat (3) step();
    chk("reset_flags", 64'({valid_out, busy, done, found}), 64'(0));
    chk("reset_counter_out", 64'(counter_out), 64'(0));
    chk("reset_found_value", 64'(found_value), 64'(0));
    RST_N = 1'b1;
    repeat (D + 2) step();
    chk("idle_flags", 64'({valid_out, busy, done, found}), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].lo, tbl[i].hi, tbl[i].tgt, tbl[i].has_t, -1, gd, gf, gfv);
      chk("vec_done_cycle", 64'(gd), 64'(tbl[i].exp_done));
      chk("vec_found", 64'(gf), 64'(tbl[i].exp_found));
      chk("vec_found_value", 64'(gfv), 64'(tbl[i].exp_fv));
    end

    // Start while busy is ignored.
    run_sweep(32'h200, 32'h20F, 32'h205, 1'b1, 3, gd, gf, gfv);
    chk("busy_start_found_value", 64'(gfv), 64'(32'h205));

    // Abort in DONE holds the captured match.
    run_sweep(32'h10, 32'h1F, 32'h12, 1'b1, -1, gd, gf, gfv);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done_flags", 64'({valid_out, busy, done, found}), 64'(4'b0001));
    chk("abort_done_found_value", 64'(found_value), 64'(32'h12));

    // Asynchronous reset while in DONE with a captured match.
    run_sweep(32'h30, 32'h33, 32'h31, 1'b1, -1, gd, gf, gfv);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_done_flags", 64'({valid_out, busy, done, found}), 64'(0));
    chk("rst_done_found_value", 64'(found_value), 64'(0));
    step();
    RST_N = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-DRAIN.
    range_lo = 32'h0;
    range_hi = 32'h3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("drain_pre_flags", 64'({valid_out, busy, done, found}), 64'(4'b0100));
    chk("drain_pre_counter_out", 64'(counter_out), 64'(3));
    #2 RST_N = 1'b0;
    #1;
    chk("rst_drain_flags", 64'({valid_out, busy, done, found}), 64'(0));
    chk("rst_drain_counter_out", 64'(counter_out), 64'(0));
    step();
    RST_N = 1'b1;
    repeat (D + 2) step();

    // Abort 10 cycles into a long sweep, then a stuck-high match_in.
    range_lo = 32'h0;
    range_hi = 32'd999;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("pre_abort_counter_out", 64'(counter_out), 64'(9));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_run_flags", 64'({valid_out, busy, done, found}), 64'(0));
    chk("abort_run_counter_held", 64'(counter_out), 64'(9));
    match_force = 1'b1;
    match_in = 1'b1;
    repeat (D + 4) begin
      step();
      chk("abort_stuck_match_flags", 64'({valid_out, busy, done, found}), 64'(0));
    end
    match_force = 1'b0;
    repeat (D + 2) step();

    // Abort and a qualified match in the same cycle.
    range_lo = 32'h0;
    range_hi = 32'd999;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (D) step();
    abort = 1'b1;
    match_force = 1'b1;
    match_in = 1'b1;
    step();
    abort = 1'b0;
    match_force = 1'b0;
    chk("abort_vs_match_flags", 64'({valid_out, busy, done, found}), 64'(0));
    chk("abort_vs_match_found_value", 64'(found_value), 64'(0));
    repeat (D + 2) step();

    // Randomized sweeps.
    for (int r = 0; r < 20; r++) begin
      len = int'($urandom_range(0, 30));
      case ($urandom_range(0, 5))
        0: begin
          lo = 32'($urandom_range(10, 1000));
          hi = lo - 32'($urandom_range(1, 5));
        end
        1: begin
          lo = 32'hFFFFFFFF - 32'($urandom_range(0, 10));
          hi = 32'hFFFFFFFF;
        end
        default: begin
          lo = $urandom;
          hi64 = longint'({32'd0, lo}) + len;
          hi = (hi64 > 64'hFFFFFFFF) ? 32'hFFFFFFFF : hi64[31:0];
        end
      endcase
      ht = ($urandom_range(0, 3) != 0);
      tg = lo + 32'($urandom_range(0, len + 3));
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : -1;
      model(lo, hi, tg, ht, e, h, dob, ve);
      run_sweep(lo, hi, tg, ht, poke, gd, gf, gfv);
      chk("rand_done_cycle", 64'(gd), 64'(dob));
      chk("rand_found", 64'(gf), 64'(h));
      if (h) chk("rand_found_value", 64'(gfv), 64'(tg));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
